// File: rtl/barrel_shifter.sv
// Registered barrel shifter: SH_DIR=0 logical left, SH_DIR=1 arithmetic right.
// One-cycle latency; no backpressure, accepts a new operation every cycle.
module barrel_shifter #(
  parameter int WIDTH  = 5,
  parameter int WIDTH2 = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VLD,
  input  logic              SH_DIR,
  input  logic [WIDTH-1:0]  SH_AMT,
  input  logic [WIDTH2-1:0] D_IN,
  output logic [WIDTH2-1:0] D_OUT,
  output logic              OUT_VLD
);

  logic [WIDTH:0][WIDTH2-1:0] stage;
  logic                       fill;

  // Sign fill comes from the original operand so every stage agrees on it.
  assign fill     = D_IN[WIDTH2-1];
  assign stage[0] = D_IN;

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [WIDTH2-1:0] shl;
    logic [WIDTH2-1:0] shr;

    assign shl          = {stage[k][WIDTH2-S-1:0], {S{1'b0}}};
    assign shr          = {{S{fill}}, stage[k][WIDTH2-1:S]};
    assign stage[k+1]   = SH_AMT[k] ? (SH_DIR ? shr : shl) : stage[k];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      D_OUT   <= '0;
      OUT_VLD <= 1'b0;
    end else begin
      OUT_VLD <= IN_VLD;
      if (IN_VLD) begin
        D_OUT <= stage[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Bench for barrel_shifter: behavioural reference model plus literal pins.
module tb_barrel_shifter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IN_VLD = 1'b0;
  logic        SH_DIR = 1'b0;
  logic [4:0]  SH_AMT = '0;
  logic [31:0] D_IN = '0;
  logic [31:0] D_OUT;
  logic        OUT_VLD;

  barrel_shifter #(.WIDTH(5), .WIDTH2(32)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN_VLD  (IN_VLD),
    .SH_DIR  (SH_DIR),
    .SH_AMT  (SH_AMT),
    .D_IN    (D_IN),
    .D_OUT   (D_OUT),
    .OUT_VLD (OUT_VLD)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic started = 1'b0;

  logic        lit_en = 1'b0;
  string       lit_name = "";
  logic        lit_vld = 1'b0;
  logic [31:0] lit_dout = '0;

  logic        exp_vld;
  logic [31:0] exp_dout;

  function automatic logic [31:0] ref_shift(input logic dir, input int amt, input logic [31:0] d);
    if (dir) return 32'($signed(d) >>> amt);
    return d << amt;
  endfunction

  // Reference: a result is whatever the operator gives, one edge later; idle cycles keep the old value.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_vld  <= 1'b0;
      exp_dout <= '0;
    end else begin
      exp_vld <= IN_VLD;
      if (IN_VLD) exp_dout <= ref_shift(SH_DIR, int'(SH_AMT), D_IN);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (started) begin
      check("model_out_vld", {31'b0, OUT_VLD}, {31'b0, exp_vld});
      check("model_d_out", D_OUT, exp_dout);
    end
    if (lit_en) begin
      check({lit_name, "_vld"}, {31'b0, OUT_VLD}, {31'b0, lit_vld});
      check({lit_name, "_dout"}, D_OUT, lit_dout);
    end
  end

  task automatic drive(input logic v, input logic dir, input int amt, input logic [31:0] d);
    @(negedge CLK);
    #1;
    lit_en = 1'b0;
    IN_VLD = v;
    SH_DIR = dir;
    SH_AMT = 5'(amt);
    D_IN   = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic pin(input string name, input logic v, input logic [31:0] d);
    lit_name = name;
    lit_vld  = v;
    lit_dout = d;
    lit_en   = 1'b1;
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    started = 1'b1;
    #1 RST = 1'b0;

    // Negative operand, arithmetic right sweep
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, 1'b1, n, 32'h8000_0000);
      if (n == 0)  pin("neg_sra_0", 1'b1, 32'h8000_0000);
      if (n == 1)  pin("neg_sra_1", 1'b1, 32'hC000_0000);
      if (n == 4)  pin("neg_sra_4", 1'b1, 32'hF800_0000);
      if (n == 31) pin("neg_sra_31", 1'b1, 32'hFFFF_FFFF);
    end

    // Positive operand, arithmetic right sweep
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, 1'b1, n, 32'h4000_0000);
      if (n == 1)  pin("pos_sra_1", 1'b1, 32'h2000_0000);
      if (n == 30) pin("pos_sra_30", 1'b1, 32'h0000_0001);
      if (n == 31) pin("pos_sra_31", 1'b1, 32'h0000_0000);
    end

    // Left shift sweep
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, 1'b0, n, 32'h0000_0001);
      if (n == 0)  pin("sll_0", 1'b1, 32'h0000_0001);
      if (n == 5)  pin("sll_5", 1'b1, 32'h0000_0020);
      if (n == 31) pin("sll_31", 1'b1, 32'h8000_0000);
    end

    // Async reset mid-cycle with nonzero output and an operation in flight
    @(posedge CLK);
    #3;
    RST = 1'b1;
    pin("rst_async", 1'b0, 32'h0000_0000);
    @(negedge CLK);
    #1;
    lit_en = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    RST    = 1'b0;
    IN_VLD = 1'b0;
    @(posedge CLK);
    #1;
    pin("post_rst", 1'b0, 32'h0000_0000);

    // Valid handshake 1,0,1,1 with hold during the idle cycle
    drive(1'b1, 1'b0, 2, 32'h0000_0003);
    pin("hs_op1", 1'b1, 32'h0000_000C);
    drive(1'b0, 1'b1, 7, 32'h1234_5678);
    pin("hs_idle", 1'b0, 32'h0000_000C);
    drive(1'b1, 1'b1, 4, 32'hF000_0000);
    pin("hs_op3", 1'b1, 32'hFF00_0000);
    drive(1'b1, 1'b0, 4, 32'hFFFF_FFFF);
    pin("hs_op4_sll_ones", 1'b1, 32'hFFFF_FFF0);

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 9) != 0, 1'($urandom), int'($urandom_range(0, 31)), $urandom);
    end

    drive(1'b0, 1'b0, 0, 32'h0);
    drive(1'b0, 1'b0, 0, 32'h0);
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
